// File: rtl/butterfly_pkg.sv
// Shared ButterFly execute-stage types and constants used by the M-extension unit.
package butterfly_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  localparam logic [31:0] MDU_DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam int unsigned MDU_ITERS      = 32;

endpackage

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add / restoring divide on a
// shared 64-bit accumulator, with a single-cycle fast path for /0 and signed overflow.
module mdu
  import butterfly_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      mdu_op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CNT_W = $clog2(MDU_ITERS);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e state_q, state_d;
  mdu_op_e    op_q, op_in;

  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_step, prod;
  logic [XLEN-1:0]   opnd_q;
  logic              neg_q, rem_neg_q;
  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN+1:0]   sum;

  logic            accept, load_result, last_iter;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_result, final_result, quot, rem;

  // Operand decode for the request being offered this cycle
  always_comb begin
    op_in    = mdu_op_e'(mdu_op_i);
    a_signed = (op_in == MDU_MULH) || (op_in == MDU_MULHSU) ||
               (op_in == MDU_DIV)  || (op_in == MDU_REM);
    b_signed = (op_in == MDU_MULH) || (op_in == MDU_DIV) || (op_in == MDU_REM);
    a_neg    = a_signed && operand_a_i[XLEN-1];
    b_neg    = b_signed && operand_b_i[XLEN-1];
    a_mag    = a_neg ? -operand_a_i : operand_a_i;
    b_mag    = b_neg ? -operand_b_i : operand_b_i;
    div_zero = mdu_op_i[2] && (operand_b_i == '0);
    div_ovf  = mdu_op_i[2] && a_signed && (operand_a_i == MIN_NEG) && (operand_b_i == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_result = mdu_op_i[1] ? operand_a_i : MDU_DIV_ZERO_Q;
    else          fast_result = mdu_op_i[1] ? '0 : operand_a_i;
  end

  // One iteration of the shared adder: add multiplicand, or trial-subtract divisor
  always_comb begin
    sum      = '0;
    acc_step = acc_q;
    if (!op_q[2]) begin
      sum      = {2'b00, acc_q[2*XLEN-1:XLEN]} + {2'b00, opnd_q};
      acc_step = acc_q[0] ? {sum[XLEN:0], acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    end else begin
      sum      = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};
      acc_step = sum[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                             : {sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  always_comb begin
    prod = neg_q ? -acc_step : acc_step;
    quot = acc_step[XLEN-1:0];
    rem  = acc_step[2*XLEN-1:XLEN];
    if (!op_q[2])      final_result = (op_q == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op_q[1])  final_result = rem_neg_q ? -rem : rem;
    else               final_result = neg_q ? -quot : quot;
  end

  always_comb begin
    state_d     = state_q;
    accept      = (state_q == IDLE) && start_i && !flush_i;
    last_iter   = (cnt_q == CNT_W'(MDU_ITERS - 1));
    load_result = 1'b0;
    result_d    = final_result;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = fast ? DONE : CALC;
          load_result = fast;
          result_d    = fast_result;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_d     = DONE;
          load_result = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d     = IDLE;
      load_result = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Multiply seeds the low half with the multiplier, divide with the dividend
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q      <= MDU_MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        op_q      <= op_in;
        cnt_q     <= '0;
        acc_q     <= {{XLEN{1'b0}}, (mdu_op_i[2] ? a_mag : b_mag)};
        opnd_q    <= mdu_op_i[2] ? b_mag : a_mag;
        neg_q     <= a_neg ^ b_neg;
        rem_neg_q <= a_neg;
      end else if (state_q == CALC) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 1'b1;
      end
      if (load_result) result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule
